// File: rtl/flash_pkg.sv
// Shared encodings for the FLASH command sequencer: FSM states, byte phases,
// the fill byte clocked out during read data, and address byte selection.
package flash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE_WAIT,
        ST_IDLE,
        ST_CSS,
        ST_LOAD,
        ST_GUARD,
        ST_WAITB,
        ST_RDHOLD,
        ST_NEXT,
        ST_CSH
    } state_t;

    typedef enum logic [2:0] {
        PH_OPC,
        PH_A2,
        PH_A1,
        PH_A0,
        PH_DATA
    } phase_t;

    localparam logic [7:0] READ_FILL = 8'h00;

    // Address goes out MSB byte first.
    function automatic logic [7:0] addr_byte(input phase_t ph, input logic [23:0] a);
        logic [7:0] b;
        b = 8'h00;
        case (ph)
            PH_A2:   b = a[23:16];
            PH_A1:   b = a[15:8];
            PH_A0:   b = a[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flash_seq_timer.sv
// 4-bit loadable down-counter; tc flags terminal count (zero). Shared by the
// chip-select setup and hold intervals.
module flash_seq_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       tc
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign tc = (cnt == 4'd0);

endmodule

// File: rtl/flash_seq.sv
// Command sequencer in front of the byte-serial FLASH shifter: frames one
// transaction under FCS and paces one byte strobe per byte on the shifter BUSY.
//
// state     | meaning
// IDLE_WAIT | shifter may still be mid-byte after reset; wait for it to go idle
// IDLE      | accept START, latch the transaction
// CSS       | FCS low, setup interval before the first strobe
// LOAD      | present the byte for the current phase and strobe it
// GUARD     | one cycle while the shifter raises BUSY
// WAITB     | wait for the shifter; capture read data
// RDHOLD    | hold read byte until the consumer accepts it
// NEXT      | advance phase / byte count
// CSH       | hold interval before FCS returns high
module flash_seq
    import flash_pkg::*;
#(
    parameter int unsigned CSS_CYC = 2,
    parameter int unsigned CSH_CYC = 2,
    parameter int unsigned NB_W    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      cmd,
    input  logic [23:0]     addr,
    input  logic            addr_en,
    input  logic            dir_rd,
    input  logic [NB_W-1:0] nbytes,
    input  logic [7:0]      wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [7:0]      rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic            sio_ws,
    output logic [7:0]      sio_dout,
    output logic            sio_rs,
    input  logic [7:0]      sio_din,
    input  logic            sio_busy,
    output logic            fcs,
    output logic            busy,
    output logic            done
);

    localparam logic [3:0] CSS_LD = 4'(CSS_CYC - 1);
    localparam logic [3:0] CSH_LD = 4'(CSH_CYC - 1);

    state_t          state, state_nx;
    phase_t          phase, phase_nx;
    logic [7:0]      cmd_q;
    logic [23:0]     addr_q;
    logic            addr_en_q, dir_rd_q;
    logic [NB_W-1:0] remain, remain_nx, left;
    logic            fcs_nx, busy_nx, done_nx, rd_valid_nx;
    logic [7:0]      rd_data_nx;
    logic            take, tmr_load, tmr_tc;
    logic [3:0]      tmr_val;

    flash_seq_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Bytes still owed after the one just finished; saturates at zero.
    assign left = (phase == PH_DATA && remain != '0) ? remain - NB_W'(1) : remain;

    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        remain_nx   = remain;
        fcs_nx      = fcs;
        busy_nx     = busy;
        done_nx     = 1'b0;
        rd_valid_nx = rd_valid;
        rd_data_nx  = rd_data;
        take        = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = CSS_LD;
        sio_ws      = 1'b0;
        sio_dout    = 8'h00;
        sio_rs      = 1'b0;
        wr_ready    = 1'b0;

        case (state)
            ST_IDLE_WAIT: if (!sio_busy) state_nx = ST_IDLE;
            ST_IDLE: begin
                if (start) begin
                    take      = 1'b1;
                    busy_nx   = 1'b1;
                    fcs_nx    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_val   = CSS_LD;
                    phase_nx  = PH_OPC;
                    remain_nx = nbytes;
                    state_nx  = ST_CSS;
                end
            end
            ST_CSS: if (tmr_tc) state_nx = ST_LOAD;
            ST_LOAD: begin
                case (phase)
                    PH_OPC: begin
                        sio_ws   = 1'b1;
                        sio_dout = cmd_q;
                    end
                    PH_DATA: begin
                        if (dir_rd_q) begin
                            sio_ws   = 1'b1;
                            sio_dout = READ_FILL;
                        end else if (wr_valid) begin
                            sio_ws   = 1'b1;
                            wr_ready = 1'b1;
                            sio_dout = wr_data;
                        end
                    end
                    default: begin
                        sio_ws   = 1'b1;
                        sio_dout = addr_byte(phase, addr_q);
                    end
                endcase
                if (sio_ws) state_nx = ST_GUARD;
            end
            ST_GUARD: state_nx = ST_WAITB;
            ST_WAITB: begin
                if (!sio_busy) begin
                    if (phase == PH_DATA && dir_rd_q) begin
                        sio_rs      = 1'b1;
                        rd_data_nx  = sio_din;
                        rd_valid_nx = 1'b1;
                        state_nx    = ST_RDHOLD;
                    end else begin
                        state_nx = ST_NEXT;
                    end
                end
            end
            ST_RDHOLD: begin
                if (rd_ready) begin
                    rd_valid_nx = 1'b0;
                    state_nx    = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (phase == PH_OPC && addr_en_q) begin
                    phase_nx = PH_A2;
                    state_nx = ST_LOAD;
                end else if (phase == PH_A2) begin
                    phase_nx = PH_A1;
                    state_nx = ST_LOAD;
                end else if (phase == PH_A1) begin
                    phase_nx = PH_A0;
                    state_nx = ST_LOAD;
                end else begin
                    remain_nx = left;
                    if (left != '0) begin
                        phase_nx = PH_DATA;
                        state_nx = ST_LOAD;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = CSH_LD;
                        state_nx = ST_CSH;
                    end
                end
            end
            ST_CSH: begin
                if (tmr_tc) begin
                    fcs_nx   = 1'b1;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE_WAIT;
            phase     <= PH_OPC;
            cmd_q     <= 8'h00;
            addr_q    <= 24'h000000;
            addr_en_q <= 1'b0;
            dir_rd_q  <= 1'b0;
            remain    <= '0;
            fcs       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            remain   <= remain_nx;
            fcs      <= fcs_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            rd_valid <= rd_valid_nx;
            rd_data  <= rd_data_nx;
            if (take) begin
                cmd_q     <= cmd;
                addr_q    <= addr;
                addr_en_q <= addr_en;
                dir_rd_q  <= dir_rd;
            end
        end
    end

endmodule

// File: tb/tb_flash_seq.sv
// Bench for flash_seq: shifter/flash model, handshake drivers and a
// transaction-level reference built from the opcode/address/data framing rules.
module tb_flash_seq;

    localparam int CSS_CYC    = 2;
    localparam int CSH_CYC    = 2;
    localparam int NB_W       = 9;
    localparam int SHIFT_BUSY = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      cmd = 8'h00;
    logic [23:0]     addr = 24'h0;
    logic            addr_en = 1'b0;
    logic            dir_rd = 1'b0;
    logic [NB_W-1:0] nbytes = '0;
    logic [7:0]      wr_data = 8'h00;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            rd_ready = 1'b1;
    logic            sio_ws;
    logic [7:0]      sio_dout;
    logic            sio_rs;
    logic [7:0]      sio_din = 8'h00;
    logic            sio_busy;
    logic            fcs;
    logic            busy;
    logic            done;

    flash_seq #(.CSS_CYC(CSS_CYC), .CSH_CYC(CSH_CYC), .NB_W(NB_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .addr(addr),
        .addr_en(addr_en), .dir_rd(dir_rd), .nbytes(nbytes),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .sio_ws(sio_ws), .sio_dout(sio_dout), .sio_rs(sio_rs),
        .sio_din(sio_din), .sio_busy(sio_busy), .fcs(fcs), .busy(busy), .done(done)
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shifter/flash model: busy the cycle after a strobe for SHIFT_BUSY cycles,
    // returns the next response byte (queued or random) in its input register.
    int         sh_cnt = 0;
    logic [7:0] resp_q[$];
    logic [7:0] din_q[$];
    assign sio_busy = (sh_cnt != 0);

    always @(posedge clk) begin : shifter
        logic [7:0] v;
        if (sio_ws) begin
            v = (resp_q.size() > 0) ? resp_q.pop_front() : 8'($urandom);
            din_q.push_back(v);
            sio_din <= v;
            sh_cnt  <= SHIFT_BUSY;
        end else if (sh_cnt != 0) begin
            sh_cnt <= sh_cnt - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ws_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] rd_got[$];
    int last_ws, min_gap, max_gap, fcs_pre, rs_n, wrr_n, done_n, done_cyc, fall_cyc, viol;
    logic done_fcs, prev_sb = 1'b0;
    int rd_stall_idx = -1, rd_stall_len = 0, rd_stall_n = 0;
    int wr_stall_idx = -1, wr_stall_len = 0, wr_stall_n = 0;
    logic rd_stalling = 1'b0, wr_stalling = 1'b0, rand_bp = 1'b0;
    logic [7:0] stall_data;

    always @(negedge clk) begin
        if (sio_ws) begin
            if (ws_q.size() > 0) begin
                if (cyc - last_ws < min_gap) min_gap = cyc - last_ws;
                if (cyc - last_ws > max_gap) max_gap = cyc - last_ws;
            end
            last_ws = cyc;
            ws_q.push_back(sio_dout);
        end else if (ws_q.size() == 0 && !fcs) begin
            fcs_pre++;
        end
        if (sio_rs) rs_n++;
        if (wr_ready) begin
            wrr_n++;
            if (wr_valid && wr_q.size() > 0) void'(wr_q.pop_front());
        end
        if (rd_valid && rd_ready) rd_got.push_back(rd_data);
        if (done) begin
            done_n++;
            done_cyc = cyc;
            done_fcs = fcs;
        end
        if (prev_sb && !sio_busy) fall_cyc = cyc;
        prev_sb = sio_busy;
        if (rd_stalling && (!rd_valid || rd_data !== stall_data || sio_ws || fcs)) viol++;
        if (wr_stalling && (sio_ws || fcs)) viol++;
    end

    always @(posedge clk) begin
        #1;
        wr_stalling = 1'b0;
        if (wr_q.size() > 0) begin
            if (wrr_n == wr_stall_idx && wr_stall_n < wr_stall_len) begin
                wr_valid = 1'b0;
                wr_stall_n++;
                wr_stalling = 1'b1;
            end else begin
                wr_valid = !(rand_bp && $urandom_range(0, 3) == 0);
                wr_data  = wr_q[0];
            end
        end else begin
            wr_valid = 1'b0;
        end
        rd_stalling = 1'b0;
        if (rd_valid && rd_got.size() == rd_stall_idx && rd_stall_n < rd_stall_len) begin
            if (rd_stall_n == 0) stall_data = rd_data;
            rd_ready = 1'b0;
            rd_stall_n++;
            rd_stalling = 1'b1;
        end else begin
            rd_ready = !(rand_bp && $urandom_range(0, 3) == 0);
        end
    end

    task automatic run_txn(input string tag, input logic [7:0] c, input logic [23:0] a,
                           input logic ae, input logic rd, input int nb, input logic poke);
        logic [7:0] exp_q[$];
        int hdr, lim;
        hdr = ae ? 4 : 1;
        exp_q.push_back(c);
        if (ae) begin
            exp_q.push_back(a[23:16]);
            exp_q.push_back(a[15:8]);
            exp_q.push_back(a[7:0]);
        end
        for (int i = 0; i < nb; i++) exp_q.push_back(rd ? 8'h00 : wr_q[i]);
        ws_q.delete(); din_q.delete(); rd_got.delete();
        min_gap = 1000000; max_gap = 0; fcs_pre = 0; rs_n = 0; wrr_n = 0;
        done_n = 0; viol = 0; rd_stall_n = 0; wr_stall_n = 0; fall_cyc = 0; done_cyc = 0;
        @(negedge clk);
        cmd = c; addr = a; addr_en = ae; dir_rd = rd; nbytes = NB_W'(nb); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lim = 400 + 25 * (hdr + nb) + wr_stall_len + rd_stall_len;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (done_n > 0) break;
            if (poke && k == 40) begin
                check({tag, "_poke_busy"}, busy, 1'b1);
                cmd = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        check({tag, "_done_seen"}, done_n, 1);
        check({tag, "_done_fcs"}, done_fcs, 1'b1);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_nstrobes"}, ws_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_strobe%0d", tag, i), ws_q[i], exp_q[i]);
            if (ws_q[i] !== exp_q[i]) break;
        end
        check({tag, "_css"}, fcs_pre, CSS_CYC);
        if (exp_q.size() > 1) check({tag, "_gap_ge18"}, min_gap >= 18, 1'b1);
        check({tag, "_rs_n"}, rs_n, rd ? nb : 0);
        check({tag, "_wr_ready_n"}, wrr_n, rd ? 0 : nb);
        check({tag, "_stall_viol"}, viol, 0);
        if (rd) begin
            check({tag, "_nreads"}, rd_got.size(), nb);
            for (int i = 0; i < nb; i++) begin
                check($sformatf("%s_rd%0d", tag, i), rd_got[i], din_q[hdr + i]);
                if (rd_got[i] !== din_q[hdr + i]) break;
            end
        end else begin
            check({tag, "_tail"}, done_cyc - fall_cyc, CSH_CYC + 2);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_fcs", fcs, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ws", sio_ws, 1'b0);
        check("rst_rs", sio_rs, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_dout", sio_dout, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        resp_q = '{8'h00, 8'hEF, 8'h40, 8'h18};
        run_txn("rdid", 8'h9F, 24'h0, 1'b0, 1'b1, 3, 1'b0);
        check("rdid_b0", rd_got[0], 8'hEF);
        check("rdid_b1", rd_got[1], 8'h40);
        check("rdid_b2", rd_got[2], 8'h18);

        wr_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        run_txn("pp", 8'h02, 24'h123456, 1'b1, 1'b0, 4, 1'b0);

        run_txn("wren", 8'h06, 24'h0, 1'b0, 1'b0, 0, 1'b0);

        rd_stall_idx = 1; rd_stall_len = 100;
        run_txn("rdstall", 8'h03, 24'h00ABCD, 1'b1, 1'b1, 3, 1'b0);
        check("rdstall_gap", max_gap >= 100, 1'b1);
        rd_stall_idx = -1; rd_stall_len = 0;

        wr_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_stall_idx = 2; wr_stall_len = 50;
        run_txn("wrstall", 8'h02, 24'hFEDCBA, 1'b1, 1'b0, 4, 1'b1);
        check("wrstall_gap", max_gap >= 50, 1'b1);
        wr_stall_idx = -1; wr_stall_len = 0;

        rand_bp = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic rd_r, ae_r;
            int nb_r;
            rd_r = 1'($urandom_range(0, 1));
            ae_r = 1'($urandom_range(0, 1));
            nb_r = $urandom_range(0, 6);
            if (!rd_r) for (int i = 0; i < nb_r; i++) wr_q.push_back(8'($urandom));
            run_txn($sformatf("rnd%0d", t), 8'($urandom), 24'($urandom), ae_r, rd_r, nb_r, 1'b0);
        end
        rand_bp = 1'b0;

        ws_q.delete();
        @(negedge clk);
        cmd = 8'h0B; addr_en = 1'b0; dir_rd = 1'b1; nbytes = NB_W'(2); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ws_q.size() >= 2 && sio_busy) break;
        end
        check("rst_mid_reached", ws_q.size() >= 2 && sio_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_fcs", fcs, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        ws_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmd = 8'h9F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_start_ignored_busy", busy, 1'b0);
        check("rst_start_ignored_fcs", fcs, 1'b1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!sio_busy) break;
        end
        repeat (3) @(negedge clk);
        check("rst_no_strobe", ws_q.size(), 0);
        check("rst_idle_busy", busy, 1'b0);

        run_txn("rd256", 8'h03, 24'h000100, 1'b1, 1'b1, 256, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
